skolem_tt_checker: RTL
======================

// Module: skolem_tt_checker
// PURPOSE
//  Sequential checker that sits directly downstream of a generated combinational
//  Skolem-function block (NUM_IN inputs -> 1 output). On start it sweeps every
//  input vector 0..2^NUM_IN-1 into the block and samples its output. Each sample
//  is compared against a golden truth table. Reports pass/fail, the mismatch count
//  and the first counterexample. Used in the synthesis flow to sign off a candidate.
// PARAMETERS
//  NUM_IN        6             width of the Skolem block input vector (1..16)
//  GOLDEN        {2**NUM_IN{1'b0}}  golden truth table; bit k = expected output for vector k
//  SETTLE_CYCLES 1             cycles from drv_vec change to sample (>=1)
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        synchronous, active-high reset
//  start         in   1        one-cycle pulse; begins a sweep when idle
//  drv_vec       out  NUM_IN   vector driven into the Skolem block (bit j -> input ij)
//  dut_out       in   1        Skolem block output for the current drv_vec
//  busy          out  1        high from the cycle after accepted start until result_valid
//  result_valid  out  1        result available; held until result_ready
//  result_ready  in   1        consumer accepts the result
//  pass          out  1        1 = zero mismatches (meaningful when result_valid)
//  mism_count    out  NUM_IN+1 number of mismatching vectors (0..2^NUM_IN)
//  cex_valid     out  1        at least one mismatch was seen
//  first_cex     out  NUM_IN   lowest-index mismatching vector; 0 if none
// BEHAVIOUR
//  Reset: state=IDLE; drv_vec=0; busy=0; result_valid=0; pass=0; mism_count=0;
//   cex_valid=0; first_cex=0; settle counter=0.
//  FSM states: IDLE, SETTLE, SAMPLE, REPORT.
//  - IDLE: if start -> clear mism_count/cex_valid/first_cex, drv_vec=0, go SETTLE.
//  - SETTLE: hold drv_vec SETTLE_CYCLES-1 extra cycles, then go SAMPLE.
//    With SETTLE_CYCLES=1, exit SETTLE after 1 cycle.
//  - SAMPLE (1 cycle): compare dut_out with GOLDEN[drv_vec].
//    On mismatch: mism_count+=1; if !cex_valid then first_cex=drv_vec, cex_valid=1.
//    If drv_vec==all-ones go REPORT; else drv_vec+=1, go SETTLE.
//  - REPORT: result_valid=1, busy=0, pass=(mism_count==0).
//    On result_valid&&result_ready -> IDLE; result_valid drops next cycle.
//    Result fields remain stable until the next accepted start.
//  Sweep latency: start to result_valid = 1 + 2^NUM_IN*(SETTLE_CYCLES+1) cycles.
//   For NUM_IN=6, SETTLE_CYCLES=1 this is 129 cycles.
//  Width rules: drv_vec counter is NUM_IN bits; the terminal test is all-ones, never wrap-around.
//   mism_count is NUM_IN+1 bits so that 2^NUM_IN cannot overflow.
//  Boundary cases:
//  - start while busy or in REPORT: ignored.
//  - start and result_ready in the same REPORT cycle: result accepted, start ignored.
//  - dut_out is sampled only in SAMPLE; its value in other states is don't-care.
//  - rst mid-sweep: immediate return to reset values; no partial result is reported.
//  - All vectors mismatch: mism_count=2^NUM_IN, first_cex=0.
// STRUCTURE
//  Shared package skolem_chk_pkg: state enum typedef (IDLE/SETTLE/SAMPLE/REPORT),
//   localparam for NUM_VEC=2**NUM_IN.
//  One natural sub-module: skolem_vec_sweeper, holding the drv_vec counter, the
//   settle counter and the last-vector flag. The compare/accumulate logic and FSM
//   stay in the top.
// TESTING
//  (Each scenario uses NUM_IN=6 and SETTLE_CYCLES=1 unless stated otherwise.)
//  1 Golden-equal model; GOLDEN = model truth table; start -> result_valid at cycle 129,
//    pass=1, mism_count=0, cex_valid=0.
//  2 Model with output forced for vector 6'd37 only -> pass=0, mism_count=1,
//    first_cex=37.
//  3 dut_out tied to ~GOLDEN -> mism_count=64, first_cex=0, cex_valid=1.
//  4 rst asserted at cycle 50 of a sweep, then start -> all outputs at reset values
//    one cycle after rst; fresh sweep gives the correct result; no stale mismatches.
//  5 Handshake: result_ready low for 10 cycles -> result_valid and fields held stable.
//    A start pulse in REPORT is ignored. result_ready=1 -> IDLE next cycle.
//  6 SETTLE_CYCLES=3, NUM_IN=2 -> result_valid exactly 1+4*4=17 cycles after start.
//    drv_vec holds each value for 4 cycles.

Source files
------------

// File: rtl/skolem_chk_pkg.sv
// Shared types and sizing helpers for the Skolem truth-table checker.
// The default vector count matches a 6-input Skolem block.
package skolem_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    REPORT
  } state_t;

  localparam int DEF_NUM_IN = 6;
  localparam int NUM_VEC = 2**DEF_NUM_IN;

  function automatic int num_vec(input int n);
    return 2**n;
  endfunction

endpackage

// File: rtl/skolem_vec_sweeper.sv
// Input-vector counter, settle timer and last-vector flag for the checker.
// The vector stops at all-ones; it never wraps back to zero.
module skolem_vec_sweeper
  import skolem_chk_pkg::*;
#(
  parameter int NUM_IN        = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              settling,
  input  logic              step,
  output logic [NUM_IN-1:0] drv_vec,
  output logic              settle_done,
  output logic              last
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [NUM_IN-1:0] VEC_ONE = 1;
  localparam logic [SW-1:0] CNT_ONE = 1;
  localparam logic [SW-1:0] CNT_END = SW'(SETTLE_CYCLES - 1);

  logic [SW-1:0] settle_cnt;

  assign settle_done = (settle_cnt == CNT_END);
  assign last        = &drv_vec;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      drv_vec    <= '0;
      settle_cnt <= '0;
    end else if (step) begin
      settle_cnt <= '0;
      if (!last)
        drv_vec <= drv_vec + VEC_ONE;
    end else if (settling && !settle_done) begin
      settle_cnt <= settle_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/skolem_tt_checker.sv
// Exhaustive truth-table checker for a combinational Skolem block.
// Sweeps every input vector, counts mismatches, keeps the first one.
module skolem_tt_checker
  import skolem_chk_pkg::*;
#(
  parameter int NUM_IN = 6,
  parameter logic [(2**NUM_IN)-1:0] GOLDEN = '0,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [NUM_IN-1:0] drv_vec,
  input  logic              dut_out,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              pass,
  output logic [NUM_IN:0]   mism_count,
  output logic              cex_valid,
  output logic [NUM_IN-1:0] first_cex
);

  localparam logic [NUM_IN:0] MISM_ONE = 1;

  state_t          state;
  logic            clr;
  logic            settling;
  logic            step;
  logic            settle_done;
  logic            last;
  logic            miss;
  logic [NUM_IN:0] mism_next;

  assign clr       = (state == IDLE) && start;
  assign settling  = (state == SETTLE);
  assign step      = (state == SAMPLE);
  assign miss      = (dut_out != GOLDEN[drv_vec]);
  assign mism_next = miss ? (mism_count + MISM_ONE) : mism_count;

  skolem_vec_sweeper #(
    .NUM_IN        (NUM_IN),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_sweeper (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .settling    (settling),
    .step        (step),
    .drv_vec     (drv_vec),
    .settle_done (settle_done),
    .last        (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      mism_count   <= '0;
      cex_valid    <= 1'b0;
      first_cex    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mism_count <= '0;
            cex_valid  <= 1'b0;
            first_cex  <= '0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_done)
            state <= SAMPLE;
        end
        SAMPLE: begin
          mism_count <= mism_next;
          if (miss && !cex_valid) begin
            first_cex <= drv_vec;
            cex_valid <= 1'b1;
          end
          if (last) begin
            busy         <= 1'b0;
            result_valid <= 1'b1;
            pass         <= (mism_next == '0);
            state        <= REPORT;
          end else begin
            state <= SETTLE;
          end
        end
        REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
